arm_ram_arbiter: RTL and testbench

- Parametrised N-channel round-robin arbiter in front of the single-port video/data RAM (`ram_2port` port A).
- Lets the ARM data port and additional masters (camera writer, debug loader) share one RAM instead of the core owning it exclusively.
- Accepts at most one request per cycle.
- Registers the RAM command and returns read data to the originating channel with fixed latency.

---
 rtl/arm_ram_arbiter.sv | 122 ++++++++++++
 tb/tb_arm_ram_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_ram_arbiter.sv
// rtl/arm_ram_arbiter.sv - N-channel round-robin arbiter in front of single-port RAM port A
// Optional build macro: ARB_CH0_PRIORITY_EN (channel 0 has absolute priority over the rotation)
module arm_ram_arbiter #(
    parameter int N_CH       = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RAM_RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH-1:0]          we,
    input  logic [N_CH*ADDR_W-1:0]   addr,
    input  logic [N_CH*DATA_W-1:0]   wdata,
    output logic [N_CH-1:0]          gnt,
    output logic [N_CH-1:0]          rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_wdata,
    output logic                     ram_wren,
    input  logic [DATA_W-1:0]        ram_q
);

    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
`ifdef ARB_CH0_PRIORITY_EN
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(1);
`else
    localparam logic [PTR_W-1:0] PTR_RST = '0;
`endif

    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    ptr_nxt;
    logic [PTR_W-1:0]    win;
    logic                any;
    int                  c;

    // Read tags: stage 0 is loaded at the acceptance edge, the last stage
    // lines up with ram_q being valid for that address.
    logic [RAM_RD_LAT:0] tag_v;
    logic [PTR_W-1:0]    tag_id [0:RAM_RD_LAT];
    logic [N_CH-1:0]     ret_onehot;

    always_comb begin
        win = '0;
        any = 1'b0;
        c   = 0;
`ifdef ARB_CH0_PRIORITY_EN
        if (req[0]) begin
            any = 1'b1;
        end else begin
            // Rotate over channels 1..N_CH-1 only.
            for (int k = 0; k < N_CH - 1; k++) begin
                c = int'(ptr) + k;
                if (c > N_CH - 1) c = c - (N_CH - 1);
                if (!any && req[PTR_W'(c)]) begin
                    any = 1'b1;
                    win = PTR_W'(c);
                end
            end
        end
`else
        for (int k = 0; k < N_CH; k++) begin
            c = int'(ptr) + k;
            if (c >= N_CH) c = c - N_CH;
            if (!any && req[PTR_W'(c)]) begin
                any = 1'b1;
                win = PTR_W'(c);
            end
        end
`endif
        if (reset) any = 1'b0;
    end

    always_comb begin
        gnt = '0;
        if (any) gnt[win] = 1'b1;
    end

    always_comb begin
        ptr_nxt = ptr;
`ifdef ARB_CH0_PRIORITY_EN
        if (win != '0) ptr_nxt = (win == PTR_W'(N_CH - 1)) ? PTR_W'(1) : win + PTR_W'(1);
`else
        ptr_nxt = (win == PTR_W'(N_CH - 1)) ? '0 : win + PTR_W'(1);
`endif
    end

    always_comb begin
        ret_onehot = '0;
        if (tag_v[RAM_RD_LAT]) ret_onehot[tag_id[RAM_RD_LAT]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= PTR_RST;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wren  <= 1'b0;
            tag_v     <= '0;
            for (int j = 0; j <= RAM_RD_LAT; j++) tag_id[j] <= '0;
            rvalid    <= '0;
            rdata     <= '0;
        end else begin
            ram_wren <= 1'b0;
            if (any) begin
                ram_addr  <= addr[int'(win)*ADDR_W +: ADDR_W];
                ram_wdata <= wdata[int'(win)*DATA_W +: DATA_W];
                ram_wren  <= we[win];
                ptr       <= ptr_nxt;
            end
            tag_v[0]  <= any && !we[win];
            tag_id[0] <= win;
            for (int j = 1; j <= RAM_RD_LAT; j++) begin
                tag_v[j]  <= tag_v[j-1];
                tag_id[j] <= tag_id[j-1];
            end
            rvalid <= ret_onehot;
            if (tag_v[RAM_RD_LAT]) rdata <= ram_q;
        end
    end

endmodule

// File: tb/tb_arm_ram_arbiter.sv
// tb/tb_arm_ram_arbiter.sv - self-checking bench for arm_ram_arbiter with behavioural reference model
module tb_arm_ram_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 1;
`ifdef ARB_CH0_PRIORITY_EN
    localparam int PTR_RST = 1;
`else
    localparam int PTR_RST = 0;
`endif

    logic              clk;
    logic              reset;
    logic [N-1:0]      req;
    logic [N-1:0]      we;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   wdata;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rvalid;
    logic [DW-1:0]     rdata;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_wdata;
    logic              ram_wren;
    logic [DW-1:0]     ram_q;

    arm_ram_arbiter #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .RAM_RD_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM port A stand-in, one cycle read latency.
    logic [DW-1:0] env_mem [0:255];
    always @(posedge clk) begin
        if (ram_wren) env_mem[ram_addr[7:0]] <= ram_wdata;
        else          ram_q <= env_mem[ram_addr[7:0]];
    end

    typedef struct {
        int          due;
        int          ch;
        logic [31:0] data;
    } rd_t;

    int            checks = 0;
    int            errors = 0;
    int            m_ptr;
    int            m_cycle = 0;
    rd_t           pend [$];
    logic [DW-1:0] ref_mem [0:255];
    logic          m_wren;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [N-1:0]  m_rvalid;
    logic [DW-1:0] m_rdata;
    logic [N-1:0]  exp_gnt;
    logic [N-1:0]  obs_gnt;

    function automatic logic [N-1:0] arb(input logic [N-1:0] r, input int p);
        logic [N-1:0] g;
        g = '0;
`ifdef ARB_CH0_PRIORITY_EN
        if (r[0]) g[0] = 1'b1;
        else for (int k = 0; k < N - 1; k++) begin
            int ch;
            ch = 1 + (p - 1 + k) % (N - 1);
            if (g == 0 && r[ch]) g[ch] = 1'b1;
        end
`else
        for (int k = 0; k < N; k++) begin
            int ch;
            ch = (p + k) % N;
            if (g == 0 && r[ch]) g[ch] = 1'b1;
        end
`endif
        return g;
    endfunction

    // Advance one clock and move the reference model across that edge.
    task automatic tick();
        int w;
        rd_t t;
        #1;
        exp_gnt = reset ? '0 : arb(req, m_ptr);
        obs_gnt = gnt;
        @(posedge clk);
        m_cycle++;
        if (reset) begin
            m_ptr = PTR_RST; m_wren = 0; m_addr = 0; m_wdata = 0;
            m_rvalid = 0; m_rdata = 0; pend.delete();
        end else begin
            m_rvalid = 0;
            if (pend.size() > 0 && pend[0].due == m_cycle) begin
                t = pend.pop_front();
                m_rvalid[t.ch] = 1'b1;
                m_rdata = t.data;
            end
            m_wren = 0;
            if (exp_gnt != 0) begin
                w = 0;
                for (int i = 0; i < N; i++) if (exp_gnt[i]) w = i;
                m_addr  = addr[w*AW +: AW];
                m_wdata = wdata[w*DW +: DW];
                m_wren  = we[w];
                if (we[w]) ref_mem[m_addr[7:0]] = m_wdata;
                else begin
                    t.due = m_cycle + LAT + 1; t.ch = w; t.data = ref_mem[m_addr[7:0]];
                    pend.push_back(t);
                end
`ifdef ARB_CH0_PRIORITY_EN
                if (w != 0) m_ptr = (w % (N - 1)) + 1;
`else
                m_ptr = (w + 1) % N;
`endif
            end
        end
        @(negedge clk);
    endtask

    task automatic set_lane(input int ch, input logic w, input logic [31:0] a, input logic [31:0] d);
        we[ch] = w;
        addr[ch*AW +: AW] = a;
        wdata[ch*DW +: DW] = d;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        req = '0;
        for (int i = 0; i < cycles; i++) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req = N'($urandom);
            we = N'($urandom);
            addr = {$urandom, $urandom, $urandom, $urandom};
            tick();
            checks++; if (obs_gnt !== '0) begin errors++; $display("FAIL reset_gnt got=%b exp=0", obs_gnt); end
            checks++; if (ram_wren !== 1'b0 || ram_addr !== '0) begin errors++; $display("FAIL reset_ram got wren=%b addr=%h exp 0/0", ram_wren, ram_addr); end
            checks++; if (rvalid !== '0 || rdata !== '0) begin errors++; $display("FAIL reset_rd got rvalid=%b rdata=%h exp 0/0", rvalid, rdata); end
        end
        reset = 1'b0;
        req = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (obs_gnt !== '0 || rvalid !== '0 || ram_wren !== 1'b0 || ram_addr !== '0) begin
                errors++; $display("FAIL idle got gnt=%b rvalid=%b wren=%b addr=%h exp all 0", obs_gnt, rvalid, ram_wren, ram_addr);
            end
        end
    endtask

    task automatic test_single_rw();
        req = 4'b0001;
        set_lane(0, 1'b1, 32'h10, 32'hDEADBEEF);
        tick();
        checks++; if (obs_gnt !== 4'b0001) begin errors++; $display("FAIL single_wr_gnt got=%b exp=0001", obs_gnt); end
        checks++; if (ram_wren !== 1'b1 || ram_addr !== 32'h10 || ram_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_wr_cmd got wren=%b addr=%h wdata=%h exp 1/10/deadbeef", ram_wren, ram_addr, ram_wdata);
        end
        set_lane(0, 1'b0, 32'h10, 32'h0);
        tick();
        checks++; if (obs_gnt !== 4'b0001 || ram_wren !== 1'b0) begin errors++; $display("FAIL single_rd_gnt got gnt=%b wren=%b exp 0001/0", obs_gnt, ram_wren); end
        req = '0;
        tick();
        checks++; if (rvalid !== '0) begin errors++; $display("FAIL single_rd_early got rvalid=%b exp=0000", rvalid); end
        tick();
        checks++; if (rvalid !== 4'b0001 || rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_rd_data got rvalid=%b rdata=%h exp 0001/deadbeef", rvalid, rdata);
        end
        tick();
        checks++; if (rvalid !== '0 || rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rd_hold got rvalid=%b rdata=%h exp 0000/deadbeef", rvalid, rdata); end
    endtask

    task automatic test_contention();
        do_reset(2);
        req = 4'b0011;
        set_lane(0, 1'b1, 32'h20, 32'hA0A0_0000);
        set_lane(1, 1'b1, 32'h21, 32'hB1B1_1111);
        tick();
        tick();
        set_lane(0, 1'b0, 32'h20, 32'h0);
        set_lane(1, 1'b0, 32'h21, 32'h0);
        do_reset(1);
        req = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) req = '0;
            tick();
            checks++; if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL contention_gnt[%0d] got=%b exp=%b", i, obs_gnt, exp_gnt); end
            checks++; if (rvalid !== m_rvalid || rdata !== m_rdata) begin
                errors++; $display("FAIL contention_rd[%0d] got rvalid=%b rdata=%h exp %b/%h", i, rvalid, rdata, m_rvalid, m_rdata);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset(2);
        req = 4'b0100;
        set_lane(2, 1'b0, 32'h5, 32'h0);
        tick();
        req = 4'b1001;
        set_lane(0, 1'b0, 32'h6, 32'h0);
        set_lane(3, 1'b0, 32'h7, 32'h0);
        tick();
        checks++; if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL wrap_gnt_a got=%b exp=%b", obs_gnt, exp_gnt); end
        req = req & ~exp_gnt;
        tick();
        checks++; if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL wrap_gnt_b got=%b exp=%b", obs_gnt, exp_gnt); end
        req = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rvalid !== m_rvalid || rdata !== m_rdata) begin
                errors++; $display("FAIL wrap_rd[%0d] got rvalid=%b rdata=%h exp %b/%h", i, rvalid, rdata, m_rvalid, m_rdata);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset(2);
        req = 4'b0010;
        set_lane(1, 1'b0, 32'h10, 32'h0);
        tick();
        checks++; if (obs_gnt !== 4'b0010) begin errors++; $display("FAIL midrd_gnt got=%b exp=0010", obs_gnt); end
        req = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (rvalid !== '0) begin errors++; $display("FAIL midrd_rvalid[%0d] got=%b exp=0000", i, rvalid); end
        end
        req = 4'b0011;
        set_lane(0, 1'b0, 32'h10, 32'h0);
        tick();
        checks++; if (obs_gnt !== 4'b0001) begin errors++; $display("FAIL midrd_after got=%b exp=0001", obs_gnt); end
        req = '0;
        tick();
        tick();
        checks++; if (rvalid !== 4'b0001 || rdata !== m_rdata) begin errors++; $display("FAIL midrd_ret got rvalid=%b rdata=%h exp 0001/%h", rvalid, rdata, m_rdata); end
    endtask

`ifdef ARB_CH0_PRIORITY_EN
    task automatic test_ch0_priority();
        do_reset(2);
        req = 4'b0011;
        set_lane(0, 1'b0, 32'h1, 32'h0);
        set_lane(1, 1'b0, 32'h2, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (obs_gnt !== 4'b0001) begin errors++; $display("FAIL prio_gnt[%0d] got=%b exp=0001", i, obs_gnt); end
        end
        req = 4'b0010;
        #1;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL prio_drop got=%b exp=0010", gnt); end
        tick();
        req = '0;
        for (int i = 0; i < 3; i++) tick();
    endtask
`endif

    task automatic test_random();
        bit pending [N];
        int waitc   [N];
        do_reset(2);
        for (int i = 0; i < N; i++) begin pending[i] = 0; waitc[i] = 0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && cyc < 380 && $urandom_range(0, 99) < 45) begin
                    pending[i] = 1;
                    set_lane(i, 1'($urandom), 32'($urandom_range(0, 31)), $urandom);
                end
                req[i] = pending[i];
            end
            tick();
            checks++; if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL rand_gnt[%0d] got=%b exp=%b", cyc, obs_gnt, exp_gnt); end
            checks++; if (ram_wren !== m_wren || ram_addr !== m_addr || ram_wdata !== m_wdata) begin
                errors++; $display("FAIL rand_cmd[%0d] got %b/%h/%h exp %b/%h/%h", cyc, ram_wren, ram_addr, ram_wdata, m_wren, m_addr, m_wdata);
            end
            checks++; if (rvalid !== m_rvalid || rdata !== m_rdata) begin
                errors++; $display("FAIL rand_rd[%0d] got rvalid=%b rdata=%h exp %b/%h", cyc, rvalid, rdata, m_rvalid, m_rdata);
            end
            for (int i = 0; i < N; i++) begin
                if (exp_gnt[i]) begin pending[i] = 0; waitc[i] = 0; end
                else if (pending[i]) waitc[i]++;
`ifndef ARB_CH0_PRIORITY_EN
                if (pending[i]) begin
                    checks++; if (waitc[i] >= N) begin errors++; $display("FAIL starve ch%0d waited=%0d limit=%0d", i, waitc[i], N - 1); end
                end
`endif
            end
        end
        req = '0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin env_mem[i] = '0; ref_mem[i] = '0; end
        reset = 1'b1;
        req = '0;
        we = '0;
        addr = '0;
        wdata = '0;
        m_ptr = PTR_RST;
        @(negedge clk);
        test_reset();
        test_single_rw();
        test_contention();
        test_wrap();
        test_reset_mid_read();
`ifdef ARB_CH0_PRIORITY_EN
        test_ch0_priority();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
